data_mem_responder: RTL and testbench

Responder end of the core's data-memory interface. It accepts one load or store request at a time from the pipeline's memory-stage controller over a valid/ready handshake and performs RV32I byte, halfword or word sizing by `func3`. After a fixed, parameterised access latency it returns sign- or zero-extended load data, or a store acknowledgement, with an error flag. A combinational watch port exposes any word to the FPGA debug display.

---
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, RV32I sizing, fixed latency,
// plus a combinational debug watch port into the word array.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [2:0]  reqFunc3,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRData,
  output logic        respErr,
  input  logic [31:0] watchAddr,
  output logic [31:0] watchData
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Array contents come up zeroed from FPGA configuration; reset never touches them.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        legal_f3;
  logic        misaligned;
  logic        in_range;
  logic        req_err;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;
  logic        mem_we;
  logic        watch_in_range;
  logic        unused_watch_lsb;

  assign unused_watch_lsb = ^watchAddr[1:0];

  // Decode the latched request: legality, lane enables and load extension.
  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    be         = 4'h0;
    st_data    = wdata_q;
    ld_data    = '0;
    in_range   = (addr_q[31:2] < 30'(DEPTH_WORDS));
    rd_word    = in_range ? mem_q[addr_q[AW+1:2]] : '0;
    rd_shift   = rd_word >> {addr_q[1:0], 3'b000};

    case (func3_q)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = !write_q;  // unsigned forms exist for loads only
      default:                legal_f3 = 1'b0;
    endcase

    case (func3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        misaligned = addr_q[0];
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{wdata_q[15:0]}};
      end
      default: begin
        misaligned = (addr_q[1:0] != 2'b00);
        be         = 4'b1111;
        st_data    = wdata_q;
      end
    endcase

    case (func3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'h0, rd_shift[7:0]};
      3'b101:  ld_data = {16'h0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase

    req_err = !legal_f3 || misaligned || !in_range;
  end

  // Handshake FSM: next state, latched request, registered response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    func3_d   = func3_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    reqReady  = 1'b0;
    respValid = 1'b0;

    unique case (state_q)
      StIdle: begin
        reqReady = 1'b1;
        if (reqValid) begin
          write_d = reqWrite;
          addr_d  = reqAddr;
          func3_d = reqFunc3;
          wdata_d = reqWData;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          err_d   = req_err;
          rdata_d = (req_err || write_q) ? 32'h0 : ld_data;
          mem_we  = write_q && !req_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        respValid = 1'b1;
        if (respReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Nothing may be accepted while reset is asserted.
    if (reset) begin
      reqReady = 1'b0;
    end
  end

  // State and request/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      func3_q <= 3'b000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane store commit; a reset on the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[addr_q[AW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign respRData      = rdata_q;
  assign respErr        = err_q;
  assign watch_in_range = (watchAddr[31:2] < 30'(DEPTH_WORDS));
  assign watchData      = watch_in_range ? mem_q[watchAddr[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [2:0]  reqFunc3;
  logic [31:0] reqWData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRData;
  logic        respErr;
  logic [31:0] watchAddr;
  logic [31:0] watchData;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWrite (reqWrite),
    .reqAddr  (reqAddr),
    .reqFunc3 (reqFunc3),
    .reqWData (reqWData),
    .respValid(respValid),
    .respReady(respReady),
    .respRData(respRData),
    .respErr  (respErr),
    .watchAddr(watchAddr),
    .watchData(watchData)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem_m [4*DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] base;
    w    = 32'h0;
    base = {a[31:2], 2'b00};
    if (a[31:2] >= 30'(DEPTH)) return 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_m[base + 32'(i)];
    return w;
  endfunction

  // Reference: byte-addressed memory, size = 1/2/4 bytes, little endian.
  task automatic model_req(input logic w, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int  size;
    bit  legal;
    legal = (f3 <= 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er    = !legal || ((a % 32'(size)) != 0) || ((a / 4) >= 32'(DEPTH));
    rd    = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[a + 32'(i)];
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
      end
    end
  endtask

  // One full request/response with respReady high; checks latency and 1-cycle response.
  task automatic transact(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input string name,
                          output logic [31:0] rd, output logic er);
    int waitc;
    int lat;
    waitc = 0;
    lat   = 0;
    @(negedge clk);
    while (!reqReady && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!reqReady) begin
      check({name, " reqReady timeout"}, 32'(reqReady), 32'd1);
      rd = 32'h0;
      er = 1'b0;
      return;
    end
    reqValid  = 1'b1;
    reqWrite  = w;
    reqAddr   = a;
    reqFunc3  = f3;
    reqWData  = wd;
    respReady = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 40);
    check({name, " latency"}, 32'(lat), 32'(LAT + 1));
    rd = respRData;
    er = respErr;
    @(negedge clk);
    check({name, " one-cycle resp"}, 32'(respValid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd, hold_d;
    logic        er, mer, hold_e, seen;
    logic        w;
    logic [31:0] a, wd;
    logic [2:0]  f3;
    int          lat, r;

    reset     = 1'b1;
    reqValid  = 1'b0;
    reqWrite  = 1'b0;
    reqAddr   = 32'h0;
    reqFunc3  = 3'b000;
    reqWData  = 32'h0;
    respReady = 1'b1;
    watchAddr = 32'h0;
    for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'h00;

    // Directed vectors: {write, addr, func3, wdata, expected rdata, expected err}
    vecs.push_back('{1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h13,   3'd0, 32'h12345680, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd0, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd4, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h80ADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h12,   3'd1, 32'hABCD8001, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd1, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd5, 32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{1'b0, 32'h11,   3'd2, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h13,   3'd1, 32'h00001111, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h8001BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h1000, 3'd2, 32'hCAFEF00D, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd3, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h10,   3'd4, 32'h000000AA, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd0, 32'h0,        32'hFFFFFFEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd1, 32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'hFFC,  3'd2, 32'h0055AA00, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'hFFE,  3'd5, 32'h0,        32'h00000055, 1'b0});
    vecs.push_back('{1'b0, 32'h11,   3'd0, 32'h0,        32'hFFFFFFBE, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd6, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h11,   3'd0, 32'h0000007F, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h11,   3'd0, 32'h0,        32'h0000007F, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h80017FEF, 1'b0});

    // Reset defaults
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reqReady during reset", 32'(reqReady), 32'd0);
    reset = 1'b0;
    #1;
    check("reset reqReady", 32'(reqReady), 32'd1);
    check("reset respValid", 32'(respValid), 32'd0);
    check("reset respRData", respRData, 32'h0);
    check("reset respErr", 32'(respErr), 32'd0);
    check("reset watchData@0", watchData, 32'h0);

    // Directed table
    foreach (vecs[i]) begin
      transact(vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd, $sformatf("vec%0d", i), rd, er);
      model_req(vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd, mrd, mer);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      watchAddr = vecs[i].a;
      #1 check($sformatf("vec%0d watch", i), watchData, model_word(vecs[i].a));
    end

    // Back-pressure: response must hold while respReady is low, new requests ignored
    @(negedge clk);
    respReady = 1'b0;
    reqValid  = 1'b1;
    reqWrite  = 1'b0;
    reqAddr   = 32'h10;
    reqFunc3  = 3'd2;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 40);
    check("bp latency", 32'(lat), 32'(LAT + 1));
    hold_d = respRData;
    hold_e = respErr;
    check("bp rdata", hold_d, model_word(32'h10));
    for (int k = 0; k < 5; k++) begin
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h10;
      reqFunc3 = 3'd2;
      reqWData = 32'h0;
      @(negedge clk);
      check($sformatf("bp respValid k%0d", k), 32'(respValid), 32'd1);
      check($sformatf("bp rdata hold k%0d", k), respRData, hold_d);
      check($sformatf("bp err hold k%0d", k), 32'(respErr), 32'(hold_e));
      check($sformatf("bp reqReady k%0d", k), 32'(reqReady), 32'd0);
    end
    reqValid  = 1'b0;
    respReady = 1'b1;
    @(negedge clk);
    check("bp release respValid", 32'(respValid), 32'd0);
    check("bp release reqReady", 32'(reqReady), 32'd1);
    watchAddr = 32'h10;
    #1 check("bp store ignored", watchData, model_word(32'h10));

    // Reset while BUSY: store aborted, no response
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr  = 32'h20;
    reqFunc3 = 3'd2;
    reqWData = 32'h12345678;
    @(posedge clk);
    #1 reqValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midop reqReady in reset", 32'(reqReady), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midop reqReady after", 32'(reqReady), 32'd1);
    check("midop respRData cleared", respRData, 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (respValid) seen = 1'b1;
    end
    check("midop no respValid", 32'(seen), 32'd0);
    watchAddr = 32'h20;
    #1 check("midop word unchanged", watchData, model_word(32'h20));

    // Randomized traffic against the reference model
    for (int it = 0; it < 200; it++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom();
      r  = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else if (r == 1) a = $urandom();
      else             a = 32'($urandom_range(0, 63));
      transact(w, a, f3, wd, $sformatf("rnd%0d", it), rd, er);
      model_req(w, a, f3, wd, mrd, mer);
      check($sformatf("rnd%0d rdata a=%08h f3=%0d w=%0d", it, a, f3, w), rd, mrd);
      check($sformatf("rnd%0d err a=%08h f3=%0d w=%0d", it, a, f3, w), 32'(er), 32'(mer));
      watchAddr = 32'($urandom_range(0, 80));
      #1 check($sformatf("rnd%0d watch %08h", it, watchAddr), watchData, model_word(watchAddr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
